divider: RTL
============

# divider

- Sequential restoring divider: the inverse of the 4x4 array multiplier.
- Takes a 2W-bit dividend (a multiplier product) and a W-bit divisor, and returns a W-bit quotient and a W-bit remainder.
- Produces one quotient bit per clock, using a start/done handshake.
- Sits beside the multiplier in the arithmetic datapath; product ÷ operand recovers the other operand.

## Interface
- W, default 4: operand width; dividend is 2W bits, quotient and remainder are W bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  2W  captured on the accepted start edge.
- divisor  input  W  captured on the accepted start edge.
- busy  output  1  high while iterating; reset 0.
- done  output  1  one-cycle pulse, results valid; reset 0.
- quotient  output  W  held until the next accepted start; reset 0.
- remainder  output  W  held until the next accepted start; reset 0.
- div_by_zero  output  1  error flag, valid with done; reset 0.
- overflow  output  1  error flag, valid with done; reset 0.

## Operation
- **FSM states:** IDLE, CALC, DONE; reset state is IDLE.
- **IDLE or DONE, start=1:**
  - Capture both operands.
  - Clear quotient, remainder and both flags.
  - Load the partial remainder R (W+1 bits) = {0, dividend[2W-1:W]}.
  - Load the shift register D = dividend[W-1:0] and set the step counter to W-1.
- **Error check on capture** (only with the macro, see Configuration):
  - divisor==0 → go to DONE; div_by_zero=1, overflow=0, quotient=all ones, remainder=dividend[W-1:0].
  - Otherwise, dividend[2W-1:W] >= divisor → go to DONE; overflow=1, quotient=all ones, remainder=0.
  - Otherwise → go to CALC.
- **CALC, each cycle:**
  - T = {R[W-1:0], D[msb]}, then shift D left.
  - If T >= divisor: R = T - divisor, quotient bit = 1; else R = T, quotient bit = 0.
  - Quotient bits shift in MSB first.
  - When the counter reaches 0 → go to DONE, remainder = R[W-1:0].
- **Arithmetic invariant:** after the valid-operand precheck, R < divisor always holds, so W+1 bits are sufficient and no carry is lost.
- **DONE:**
  - done=1 for exactly one cycle.
  - Next state: start=1 → new capture (back-to-back); otherwise IDLE.
- **start while busy=1:** ignored; operands are not sampled.
- **Reset mid-operation:** immediately returns to IDLE with all outputs at their reset values; no done pulse follows.

## Timing
- start accepted at edge k → busy=1 from k+1 through k+W, i.e. W cycles.
- Valid operation: done=1 in cycle k+W+1; total latency W+1 cycles.
- Error operation: done=1 in cycle k+1 and busy never rises.
- quotient, remainder and flags are updated no later than the done cycle and held stable afterwards.
- Back-to-back operation:
  - start is accepted in the done cycle.
  - busy rises on the next edge; the held outputs clear at that edge.
  - Sustained throughput is one result per W+1 cycles.

## Configuration
- **DIVIDER_ERR_CHECK_EN defined:**
  - The divide-by-zero and overflow checks apply exactly as above, with the early exit to DONE.
- **DIVIDER_ERR_CHECK_EN undefined:**
  - div_by_zero and overflow are tied 0.
  - Every accepted start runs the full W CALC cycles.
  - For operands with dividend[2W-1:W] >= divisor (including divisor=0), quotient and remainder are undefined and not checked.
  - For all other operands, behaviour and timing are identical to the defined build.

## Test plan
- **Basic division** (W=4): dividend=100, divisor=7 → busy for 4 cycles, done at k+5, quotient=14, remainder=2, flags 0.
- **Full scale:** dividend=225, divisor=15 → quotient=15, remainder=0.
- **Error cases** (macro defined):
  - dividend=0x80, divisor=7 → done at k+1, overflow=1, quotient=0xF, remainder=0.
  - divisor=0, dividend=0x35 → done at k+1, div_by_zero=1, quotient=0xF, remainder=5.
- **Round trip, exhaustive** over all a, b in 1..15 with W=4: dividend=a*b, divisor=b → quotient=a, remainder=0.
- **Handshake and reset:**
  - start held through CALC with changing operands → ignored; the result matches the first operands.
  - start asserted in the done cycle → a second result is produced 5 cycles later.
  - rst_n pulsed low at CALC cycle 2 → all outputs return to 0 asynchronously and no done pulse follows.

Source files
------------

// File: rtl/divider_if.sv
// Operand/result bundle for the sequential divider.
//   master : start, dividend, divisor  -> divider
//   slave  : busy, done, quotient, remainder, div_by_zero, overflow <- divider
interface divider_if #(
  parameter int unsigned W = 4
);
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, start/done handshake.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - divider_if.slave: start/dividend/divisor in;
//           busy/done/quotient/remainder/div_by_zero/overflow out (registered)
// Optional feature macro: DIVIDER_ERR_CHECK_EN enables divide-by-zero and
// overflow detection with an early exit to DONE; otherwise both flags are 0.
module divider #(
  parameter int unsigned W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  divider_if.slave bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         r_state;
  logic [W:0]     r_rem;        // partial remainder, one guard bit
  logic [W-1:0]   r_d;          // low dividend bits still to shift in
  logic [W-1:0]   r_divisor;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_quot;
  logic [W-1:0]   r_remainder;
`ifdef DIVIDER_ERR_CHECK_EN
  logic           r_dz;
  logic           r_ov;
`endif

  logic [W:0]     w_t;
  logic           w_ge;
  logic [W:0]     w_diff;
  logic [W:0]     w_next_rem;
  logic [W-1:0]   w_hi;
  logic [W-1:0]   w_lo;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_t        = {r_rem[W-1:0], r_d[W-1]};
  assign w_ge       = (w_t >= {1'b0, r_divisor});
  assign w_diff     = w_t - {1'b0, r_divisor};
  assign w_next_rem = w_ge ? w_diff : w_t;

  assign w_hi = bus.dividend[2*W-1:W];
  assign w_lo = bus.dividend[W-1:0];

  // Control, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_d         <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quot      <= '0;
      r_remainder <= '0;
`ifdef DIVIDER_ERR_CHECK_EN
      r_dz        <= 1'b0;
      r_ov        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_divisor   <= bus.divisor;
            r_rem       <= {1'b0, w_hi};
            r_d         <= w_lo;
            r_cnt       <= CW'(W - 1);
            r_quot      <= '0;
            r_remainder <= '0;
`ifdef DIVIDER_ERR_CHECK_EN
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
            if (bus.divisor == '0) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_dz        <= 1'b1;
              r_quot      <= '1;
              r_remainder <= w_lo;
            end else if (w_hi >= bus.divisor) begin
              // Quotient would not fit in W bits.
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_ov        <= 1'b1;
              r_quot      <= '1;
            end else begin
              r_state <= CALC;
              r_busy  <= 1'b1;
            end
`else
            r_state <= CALC;
            r_busy  <= 1'b1;
`endif
          end else begin
            r_state <= IDLE;
          end
        end

        CALC: begin
          r_rem  <= w_next_rem;
          r_d    <= r_d << 1;
          r_quot <= (r_quot << 1) | W'(w_ge);
          if (r_cnt == '0) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_remainder <= w_next_rem[W-1:0];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remainder;
`ifdef DIVIDER_ERR_CHECK_EN
  assign bus.div_by_zero = r_dz;
  assign bus.overflow    = r_ov;
`else
  assign bus.div_by_zero = 1'b0;
  assign bus.overflow    = 1'b0;
`endif

endmodule
